// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_mem port between the CPU load/store unit (C) and the loader/debug port (D).
// Grant is combinational in the request cycle; load data is tagged back to its port exactly one cycle after grant.
// Illegal/misaligned requests get a one-cycle err and never reach memory. Optional macro DMEM_ARB_RR_EN: round-robin (default fixed C>D).
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [5:0]        c_alucode,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_err,
  output logic              c_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [5:0]        d_alucode,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_err,
  output logic              d_rvalid,
  output logic [31:0]       rdata,
  output logic [5:0]        m_alucode,
  output logic              m_is_load,
  output logic              m_is_store,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  // Access-kind codes, mirroring the ALU_LB..ALU_SW values of define.vh.
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Code must match the access direction; halfwords may not start at byte 3,
  // words must be word aligned.
  function automatic logic access_ok(input logic we, input logic [5:0] code,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (!we) begin
      case (code)
        ALU_LB, ALU_LBU: ok = 1'b1;
        ALU_LH, ALU_LHU: ok = (off != 2'd3);
        ALU_LW:          ok = (off == 2'd0);
        default:         ok = 1'b0;
      endcase
    end else begin
      case (code)
        ALU_SB:  ok = 1'b1;
        ALU_SH:  ok = (off != 2'd3);
        ALU_SW:  ok = (off == 2'd0);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  logic        c_legal, d_legal;
  logic        c_ok, d_ok;
  logic        pick_c, pick_d;
  logic        resp_v_q, resp_v_d;
  logic        resp_port_q, resp_port_d;
  logic [15:0] gnt_cnt_c, gnt_cnt_d;

  // Screen both requesters; everything is gated off while reset is held.
  always_comb begin
    c_legal = access_ok(c_we, c_alucode, c_addr[1:0]);
    d_legal = access_ok(d_we, d_alucode, d_addr[1:0]);
    c_ok    = rst_n & c_req & c_legal;
    d_ok    = rst_n & d_req & d_legal;
    c_err   = rst_n & c_req & ~c_legal;
    d_err   = rst_n & d_req & ~d_legal;
  end

`ifdef DMEM_ARB_RR_EN
  logic prio_q, prio_d;  // port preferred on the next conflict

  assign pick_c = c_ok & (~d_ok | (prio_q == PORT_C));

  // After a grant the other port becomes preferred.
  always_comb begin
    prio_d = prio_q;
    if (pick_c)      prio_d = PORT_D;
    else if (pick_d) prio_d = PORT_C;
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PORT_C;
    else        prio_q <= prio_d;
  end
`else
  assign pick_c = c_ok;
`endif

  assign pick_d = d_ok & ~pick_c;
  assign c_gnt  = pick_c;
  assign d_gnt  = pick_d;

  // Drive the memory port from the winner; park everything at 0 when idle.
  always_comb begin
    m_is_load  = 1'b0;
    m_is_store = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_alucode  = '0;
    if (pick_c) begin
      m_is_load  = ~c_we;
      m_is_store = c_we;
      m_addr     = c_addr;
      m_wdata    = c_wdata;
      m_alucode  = c_alucode;
    end else if (pick_d) begin
      m_is_load  = ~d_we;
      m_is_store = d_we;
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      m_alucode  = d_alucode;
    end
  end

  // A granted load expects data next cycle; remember who asked for it.
  always_comb begin
    resp_v_d    = (pick_c & ~c_we) | (pick_d & ~d_we);
    resp_port_d = pick_d ? PORT_D : PORT_C;
  end

  // Response stage; reset drops any load still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_v_q    <= 1'b0;
      resp_port_q <= PORT_C;
    end else begin
      resp_v_q    <= resp_v_d;
      resp_port_q <= resp_port_d;
    end
  end

  // Per-port grant counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_c <= 16'd0;
      gnt_cnt_d <= 16'd0;
    end else begin
      if (pick_c) gnt_cnt_c <= gnt_cnt_c + 16'd1;
      if (pick_d) gnt_cnt_d <= gnt_cnt_d + 16'd1;
    end
  end

  assign c_rvalid = resp_v_q & (resp_port_q == PORT_C);
  assign d_rvalid = resp_v_q & (resp_port_q == PORT_D);
  assign rdata    = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by held random requests,
// checked against a word-level memory/arbitration reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam logic [5:0] LB  = 6'd16;
  localparam logic [5:0] LH  = 6'd17;
  localparam logic [5:0] LW  = 6'd18;
  localparam logic [5:0] LBU = 6'd19;
  localparam logic [5:0] LHU = 6'd20;
  localparam logic [5:0] SB  = 6'd21;
  localparam logic [5:0] SH  = 6'd22;
  localparam logic [5:0] SW  = 6'd23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [5:0]  c_alucode = '0, d_alucode = '0;
  logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
  logic        c_gnt, c_err, c_rvalid, d_gnt, d_err, d_rvalid;
  logic [31:0] rdata, m_addr, m_wdata, m_rdata;
  logic [5:0]  m_alucode;
  logic        m_is_load, m_is_store;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_alucode(c_alucode), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_err(c_err), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_we(d_we), .d_alucode(d_alucode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_err(d_err), .d_rvalid(d_rvalid),
    .rdata(rdata), .m_alucode(m_alucode), .m_is_load(m_is_load), .m_is_store(m_is_store),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // ---------------- data_mem stand-in (byte array, registered read) ----------------
  bit   [7:0]  smem [0:4095];
  logic [11:0] sa;
  assign sa = m_addr[11:0];

  function automatic logic [31:0] stub_read(input logic [5:0] code, input logic [11:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = smem[a]; b1 = smem[a + 12'd1]; b2 = smem[a + 12'd2]; b3 = smem[a + 12'd3];
    case (code)
      LB:      return {{24{b0[7]}}, b0};
      LBU:     return {24'h0, b0};
      LH:      return {{16{b1[7]}}, b1, b0};
      LHU:     return {16'h0, b1, b0};
      LW:      return {b3, b2, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (m_is_store) begin
      case (m_alucode)
        SB: smem[sa] <= m_wdata[7:0];
        SH: begin smem[sa] <= m_wdata[7:0]; smem[sa + 12'd1] <= m_wdata[15:8]; end
        SW: begin
          smem[sa] <= m_wdata[7:0];          smem[sa + 12'd1] <= m_wdata[15:8];
          smem[sa + 12'd2] <= m_wdata[23:16]; smem[sa + 12'd3] <= m_wdata[31:24];
        end
        default: ;
      endcase
    end
    if (m_is_load) m_rdata <= stub_read(m_alucode, sa);
  end

  // ---------------- reference model ----------------
  bit [31:0]   mw [int unsigned];   // word-addressed memory image
  bit          pend_v;
  bit          pend_port;           // 0 = C, 1 = D
  logic [31:0] pend_data;
  bit          pref_d;              // conflict goes to D when set
  logic [15:0] cnt_c, cnt_d;
  int          win;                 // 0 none, 1 C, 2 D
  bit          exp_c_err, exp_d_err;

  function automatic bit model_legal(input bit we, input logic [5:0] code, input logic [31:0] a);
    bit is_ld, is_st;
    int sz;
    is_ld = (code == LB) || (code == LBU) || (code == LH) || (code == LHU) || (code == LW);
    is_st = (code == SB) || (code == SH) || (code == SW);
    sz = (code == LW || code == SW) ? 4 : (code == LH || code == LHU || code == SH) ? 2 : 1;
    if (we ? !is_st : !is_ld) return 1'b0;
    return (int'(a % 4) + sz) <= 4;   // access must stay inside one word
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return mw.exists(a / 4) ? mw[a / 4] : 32'h0;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] code, input logic [31:0] a);
    logic [31:0] v;
    v = model_word(a) >> (8 * (a % 4));
    case (code)
      LB:      return {{24{v[7]}}, v[7:0]};
      LBU:     return {24'h0, v[7:0]};
      LH:      return {{16{v[15]}}, v[15:0]};
      LHU:     return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic model_store(input logic [5:0] code, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w, mask;
    int sh;
    sh   = 8 * int'(a % 4);
    mask = (code == SB) ? 32'hFF : (code == SH) ? 32'hFFFF : 32'hFFFF_FFFF;
    w    = model_word(a);
    w    = (w & ~(mask << sh)) | ((wd & mask) << sh);
    mw[a / 4] = w;
  endtask

  task automatic model_reset();
    pend_v = 0; pref_d = 0; cnt_c = 16'd0; cnt_d = 16'd0; win = 0;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic drive_check(input string tag);
    bit cok, dok;
    @(negedge clk);
    cok = rst_n && c_req && model_legal(c_we, c_alucode, c_addr);
    dok = rst_n && d_req && model_legal(d_we, d_alucode, d_addr);
    exp_c_err = rst_n && c_req && !cok;
    exp_d_err = rst_n && d_req && !dok;
    if (cok && dok) win = pref_d ? 2 : 1;
    else if (cok)   win = 1;
    else if (dok)   win = 2;
    else            win = 0;
    check1({tag, ".c_gnt"}, c_gnt, win == 1);
    check1({tag, ".d_gnt"}, d_gnt, win == 2);
    check1({tag, ".c_err"}, c_err, exp_c_err);
    check1({tag, ".d_err"}, d_err, exp_d_err);
    check1({tag, ".m_is_load"},  m_is_load,  (win == 1 && !c_we) || (win == 2 && !d_we));
    check1({tag, ".m_is_store"}, m_is_store, (win == 1 && c_we) || (win == 2 && d_we));
    check32({tag, ".m_addr"},  m_addr,  win == 1 ? c_addr : win == 2 ? d_addr : 32'h0);
    check32({tag, ".m_wdata"}, m_wdata, win == 1 ? c_wdata : win == 2 ? d_wdata : 32'h0);
    check32({tag, ".m_alucode"}, {26'h0, m_alucode},
            {26'h0, win == 1 ? c_alucode : win == 2 ? d_alucode : 6'h0});
    check1({tag, ".c_rvalid"}, c_rvalid, pend_v && !pend_port);
    check1({tag, ".d_rvalid"}, d_rvalid, pend_v && pend_port);
    if (pend_v) check32({tag, ".rdata"}, rdata, pend_data);
    check32({tag, ".gnt_cnt_c"}, {16'h0, dut.gnt_cnt_c}, {16'h0, cnt_c});
    check32({tag, ".gnt_cnt_d"}, {16'h0, dut.gnt_cnt_d}, {16'h0, cnt_d});
`ifdef DMEM_ARB_RR_EN
    check1({tag, ".prio"}, dut.prio_q, pref_d);
`endif
  endtask

  // Advance the model across the rising edge.
  task automatic commit();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      pend_v = 0;
      if (win != 0) begin
        bit          p, we;
        logic [5:0]  code;
        logic [31:0] a, wd;
        p = (win == 2);
        we = p ? d_we : c_we; code = p ? d_alucode : c_alucode;
        a  = p ? d_addr : c_addr; wd = p ? d_wdata : c_wdata;
        if (p) cnt_d = cnt_d + 16'd1; else cnt_c = cnt_c + 16'd1;
        if (we) model_store(code, a, wd);
        else begin pend_v = 1; pend_port = p; pend_data = model_load(code, a); end
`ifdef DMEM_ARB_RR_EN
        pref_d = !p;
`endif
      end
    end
    #1;
  endtask

  task automatic set_c(input bit req, input bit we, input logic [5:0] code,
                       input logic [31:0] a, input logic [31:0] wd);
    c_req = req; c_we = we; c_alucode = code; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [5:0] code,
                       input logic [31:0] a, input logic [31:0] wd);
    d_req = req; d_we = we; d_alucode = code; d_addr = a; d_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    model_reset();
    drive_check("reset");
    commit();
    rst_n = 1'b1;
  endtask

  logic [5:0] codes [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  task automatic rand_req(output bit req, output bit we, output logic [5:0] code,
                          output logic [31:0] a, output logic [31:0] wd);
    req  = ($urandom_range(0, 3) != 0);
    code = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 7)];
    we   = (code == SB || code == SH || code == SW);
    if ($urandom_range(0, 9) == 0) we = !we;
    a    = 32'h200 + $urandom_range(0, 63);
    wd   = $urandom;
  endtask

  initial begin
    bit          rq, rw;
    logic [5:0]  rc;
    logic [31:0] ra, rwd;

    // Reset state, with both ports requesting to prove the gating.
    model_reset();
    set_c(1, 0, LW, 32'h100, 32'h0);
    set_d(1, 0, 6'h3F, 32'h100, 32'h0);
    drive_check("rst_hold");
    commit();
    do_reset();

    // Port C: store a word, then a signed byte load from its top byte.
    set_c(1, 1, SW, 32'h100, 32'hDEADBEEF);
    drive_check("sw100");
    check1("sw100.gnt", c_gnt, 1'b1);
    commit();
    set_c(1, 0, LB, 32'h103, 32'h0);
    drive_check("lb103");
    check1("lb103.gnt", c_gnt, 1'b1);
    commit();
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("lb103_resp");
    check1("lb103.rvalid", c_rvalid, 1'b1);
    check32("lb103.rdata", rdata, 32'hFFFF_FFDE);
    commit();

    // Misaligned word load and halfword store.
    set_c(1, 0, LW, 32'h102, 32'h0);
    drive_check("lw102");
    check1("lw102.err", c_err, 1'b1);
    check1("lw102.gnt", c_gnt, 1'b0);
    commit();
    set_c(1, 1, SH, 32'h107, 32'h1234);
    drive_check("sh107");
    check1("sh107.err", c_err, 1'b1);
    check1("sh107.store", m_is_store, 1'b0);
    commit();
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("mis_idle");
    check1("mis_idle.rvalid", c_rvalid, 1'b0);
    commit();

    // Contention: both ports issue LW every cycle for four cycles.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_c(1, 0, LW, 32'h100, 32'h0);
      set_d(1, 0, LW, 32'h104, 32'h0);
      drive_check("cont");
`ifdef DMEM_ARB_RR_EN
      check1("cont.c_gnt_order", c_gnt, (k % 2) == 0);
      check1("cont.d_gnt_order", d_gnt, (k % 2) == 1);
      if (k > 0) check1("cont.d_tag", d_rvalid, (k % 2) == 0);
`else
      check1("cont.c_gnt_fixed", c_gnt, 1'b1);
      check1("cont.d_wait", d_gnt, 1'b0);
`endif
      commit();
    end
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
`ifdef DMEM_ARB_RR_EN
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("cont_end");
    check32("cont.cnt_c", {16'h0, dut.gnt_cnt_c}, 32'd2);
    check32("cont.cnt_d", {16'h0, dut.gnt_cnt_d}, 32'd2);
`else
    drive_check("cont_end");
    check1("cont.d_gnt_on_drop", d_gnt, 1'b1);
`endif
    commit();
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("cont_tail");
    commit();

    // Store from D followed immediately by a load from C of the same byte.
    set_d(1, 1, SB, 32'h201, 32'h0000_005A);
    drive_check("sb201");
    commit();
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    set_c(1, 0, LBU, 32'h201, 32'h0);
    drive_check("lbu201");
    commit();
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("lbu201_resp");
    check1("lbu201.rvalid", c_rvalid, 1'b1);
    check32("lbu201.rdata", rdata, 32'h0000_005A);
    commit();

    // Reset while a D load is in flight.
    set_d(1, 0, LW, 32'h200, 32'h0);
    drive_check("rst_mid");
    check1("rst_mid.gnt", d_gnt, 1'b1);
    #1 rst_n = 1'b0;
    model_reset();
    set_c(1, 0, LW, 32'h200, 32'h0);
    set_d(1, 0, 6'h3F, 32'h200, 32'h0);
    commit();
    drive_check("in_rst");
    check1("in_rst.d_rvalid", d_rvalid, 1'b0);
    check1("in_rst.c_gnt", c_gnt, 1'b0);
    check1("in_rst.d_err", d_err, 1'b0);
    commit();
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    drive_check("post_rst_idle");
    check1("post_rst.d_rvalid", d_rvalid, 1'b0);
    commit();
    set_d(1, 0, LW, 32'h200, 32'h0);
    drive_check("post_rst_lw");
    check1("post_rst.gnt", d_gnt, 1'b1);
    commit();
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("post_rst_resp");
    check1("post_rst.rvalid", d_rvalid, 1'b1);
    commit();

    // Random traffic; a request is held until the model says it was granted or rejected.
    for (int i = 0; i < 500; i++) begin
      if (!c_req || win == 1 || exp_c_err) begin
        rand_req(rq, rw, rc, ra, rwd);
        set_c(rq, rw, rc, ra, rwd);
      end
      if (!d_req || win == 2 || exp_d_err) begin
        rand_req(rq, rw, rc, ra, rwd);
        set_d(rq, rw, rc, ra, rwd);
      end
      drive_check("rand");
      commit();
    end
    set_c(0, 0, 6'h0, 32'h0, 32'h0);
    set_d(0, 0, 6'h0, 32'h0, 32'h0);
    drive_check("rand_drain");
    commit();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer in front of `data_mem`. It shares the single data-memory port between the CPU load/store unit (port C) and the program loader/debug port (port D). It screens misaligned or illegal accesses and tags the one-cycle-late read data back to the port that issued the load. Back-to-back accesses are supported every cycle, with no bubbles.

## Interface
- `ADDR_W`, 32, address width of both request ports and the memory side.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  port C access request; held until `c_gnt` or `c_err`.
- `c_we`  in  1  port C access type: 1 = store, 0 = load.
- `c_alucode`  in  6  port C access kind, from the `ALU_LB`..`ALU_SW` codes in `define.vh`.
- `c_addr`  in  ADDR_W  port C byte address.
- `c_wdata`  in  32  port C store data.
- `c_gnt`  out  1  port C request accepted this cycle.
- `c_err`  out  1  port C request rejected this cycle.
- `c_rvalid`  out  1  port C load data valid this cycle.
- `d_req`, `d_we`, `d_alucode`, `d_addr`, `d_wdata`, `d_gnt`, `d_err`, `d_rvalid`  same as the port C signals, for port D.
- `rdata`  out  32  shared read data, qualified by `c_rvalid`/`d_rvalid`.
- `m_alucode`  out  6  to data_mem `alucode`.
- `m_is_load`  out  1  to data_mem `is_load`.
- `m_is_store`  out  1  to data_mem `is_store`.
- `m_addr`  out  ADDR_W  to data_mem `addr`.
- `m_wdata`  out  32  to data_mem `w_data`.
- `m_rdata`  in  32  from data_mem `r_data`.

## Operation
- **Legality check.** Each cycle, every requesting port is checked combinationally.
  - Loads are legal with `LB`, `LBU`, `LH`, `LHU`, `LW`. Stores are legal with `SB`, `SH`, `SW`.
  - An access is misaligned when `LH`/`LHU`/`SH` has `addr[1:0]==3`, or `LW`/`SW` has `addr[1:0]!=0`.
  - An illegal code or a misaligned access raises the port's `err` for one cycle. The access is never issued to memory and consumes no arbitration slot.
- **Arbitration.** Among legal requesters, one winner is picked per cycle; the policy is set under Configuration.
  - The winner's `gnt` is 1 in the same cycle.
  - `m_*` are driven combinationally from the winner: `m_is_store = we`, `m_is_load = !we`.
  - With no winner, `m_is_load = m_is_store = 0`. `m_addr`, `m_wdata` and `m_alucode` are then don't-care but held at 0.
- **Response tracking.** A registered response stage holds `resp_v` and `resp_port`.
  - On each granted load, `resp_v <= 1` and `resp_port` <= the winning port.
  - Otherwise `resp_v <= 0`.
  - `c_rvalid = resp_v & (resp_port==C)`; `d_rvalid = resp_v & (resp_port==D)`.
  - `rdata = m_rdata` passes straight through.
- Stores produce no response; a granted store is complete at the grant edge.
- Counters `gnt_cnt_c` and `gnt_cnt_d` (16-bit, wrap at 0xFFFF->0) increment on each grant. They are internal and visible to the bench through hierarchy.
- **Reset.** While `rst_n` is low:
  - all `gnt`, `err` and `rvalid` outputs are 0;
  - `m_is_load` and `m_is_store` are 0;
  - `resp_v`, the priority pointer and both counters are 0.
- If reset asserts while a load is in flight, its response is dropped, with no `rvalid` after reset release.

## Timing
- Request to grant: 0 cycles (combinational). Grant edge to `rvalid`/`rdata`: exactly 1 cycle.
- Throughput: one access per cycle. Two consecutive loads to different ports give `rvalid` on consecutive cycles with the correct port tags.
- A load in cycle N and a store in cycle N+1 to the same word: the load returns the pre-store value.
- A store in cycle N and a load in cycle N+1 to the same word: the load returns the post-store value.
- Simultaneous legal requests: exactly one `gnt`. The loser keeps `req` high and is served in a later cycle.
- One port illegal and the other legal in the same cycle: `err` goes to the first port and `gnt` to the second, both in that cycle.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port. After any grant it moves to the other port.
  - On a conflict, the preferred port wins. Reset value: prefer C.
- `DMEM_ARB_RR_EN` undefined: fixed priority. C always beats D, and no pointer register is built.

## Test plan
- Port C only: `SW` 0xDEADBEEF to 0x100, then `LB` from 0x103. Required: `c_gnt` on both cycles; `c_rvalid` one cycle after the `LB` grant with `rdata`=0xFFFFFFDE.
- Misalignment: port C `LW` to 0x102, then `SH` to 0x107. Required: `c_err`=1 and `c_gnt`=0 for each; `m_is_load`=`m_is_store`=0; no `c_rvalid`.
- Contention, RR build: C and D both issue `LW` each cycle for 4 cycles. Required: grant order C,D,C,D; `rvalid` tags alternate one cycle later; `gnt_cnt_c`=`gnt_cnt_d`=2.
- Contention, fixed build: the same stimulus. Required: only `c_gnt` fires and D waits; when C drops `req`, `d_gnt` fires in that same cycle.
- Reset mid-flight: D `LW` granted, then `rst_n` low in the next cycle before the edge. Required: `d_rvalid` stays 0; all outputs are 0 during reset; the first post-reset access behaves normally.
- Write-then-read: D `SB` 0x5A to 0x201 in cycle N, C `LBU` 0x201 in cycle N+1. Required: `c_rvalid` at N+2 with `rdata`=0x0000005A.
